// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle for regfile_write_arbiter: writeback and long-latency result
// handshakes, issue/decode hazard queries, and the register file write port.
// The master modport is the pipeline side; the slave modport is the arbiter.
interface regfile_write_arbiter_if;
  // writeback stage
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  // long-latency unit result
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  // long-latency issue and decode hazard lookups
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  // register file write port
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  modport master (
    output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
           iss_valid, iss_rd, rs1, rs2,
    input  wb_ready, lu_ready, iss_ready, rs1_busy, rs2_busy,
           rf_we, rf_rd, rf_data
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
           iss_valid, iss_rd, rs1, rs2,
    output wb_ready, lu_ready, iss_ready, rs1_busy, rs2_busy,
           rf_we, rf_rd, rf_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register file write port between
// the in-order writeback stage and an out-of-order long-latency unit.
// Long-latency results wait in a 2-entry FIFO; writeback has priority unless
// the FIFO head has lost STARVE_LIMIT consecutive cycles, then it is forced.
// Optional destination scoreboard: define REGFILE_WRARB_SCOREBOARD_EN.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // 1..15
) (
  input  logic                     clk,
  input  logic                     rst,  // asynchronous, active-low
  regfile_write_arbiter_if.slave   bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_entry_t;

  wr_entry_t   fifo_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [3:0]  sc;

  logic        fifo_empty;
  logic        fifo_full;
  wr_entry_t   head;
  logic        force_lu;
  logic        grant_lu;
  logic        grant_wb;
  logic        push;
  logic        pop;
  logic [4:0]  grant_rd;
  logic [31:0] grant_data;

  assign fifo_empty = (count == 2'd0);
  assign fifo_full  = (count == 2'd2);
  assign head       = fifo_mem[rd_ptr];

  // A buffered write that has starved long enough pre-empts writeback.
  assign force_lu = !fifo_empty && (sc >= STARVE_LIM);
  assign grant_lu = force_lu || (!bus.wb_valid && !fifo_empty);
  assign grant_wb = !force_lu && bus.wb_valid;

  // lu_ready looks only at the pre-pop state, so a full FIFO never pushes
  // in the same cycle it pops.
  assign bus.lu_ready = !fifo_full;
  assign bus.wb_ready = !force_lu;

  assign push = bus.lu_valid && bus.lu_ready;
  assign pop  = grant_lu;

  // Select the source that owns the write port this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    grant_rd   = '0;
    grant_data = '0;
    if (grant_lu) begin
      grant_rd   = head.rd;
      grant_data = head.data;
    end else if (grant_wb) begin
      grant_rd   = bus.wb_rd;
      grant_data = bus.wb_data;
    end
  end

  // FIFO pointers, occupancy and the starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      sc     <= 4'd0;
    end else begin
      rd_ptr <= rd_ptr ^ pop;
      wr_ptr <= wr_ptr ^ push;
      count  <= count + 2'(push) - 2'(pop);
      if (pop || fifo_empty) begin
        sc <= 4'd0;
      end else if (grant_wb && (sc != 4'hF)) begin
        sc <= sc + 4'd1;
      end
    end
  end

  // FIFO payload storage.
  // NOTE: payload storage is deliberately not reset; occupancy is, and an
  // entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{rd: bus.lu_rd, data: bus.lu_data};
    end
  end

  // Registered register-file write port; writes to x0 are suppressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rf_we   <= 1'b0;
      bus.rf_rd   <= 5'd0;
      bus.rf_data <= 32'd0;
    end else begin
      bus.rf_we <= (grant_lu || grant_wb) && (grant_rd != 5'd0);
      if (grant_lu || grant_wb) begin
        bus.rf_rd   <= grant_rd;
        bus.rf_data <= grant_data;
      end
    end
  end

`ifdef REGFILE_WRARB_SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busy_next;
  logic        iss_fire;

  assign bus.iss_ready = (bus.iss_rd == 5'd0) || !busy[bus.iss_rd];
  assign iss_fire      = bus.iss_valid && bus.iss_ready && (bus.iss_rd != 5'd0);
  assign bus.rs1_busy  = (bus.rs1 != 5'd0) && busy[bus.rs1];
  assign bus.rs2_busy  = (bus.rs2 != 5'd0) && busy[bus.rs2];

  // Clear on buffered grant, then set on issue, so a same-rd set wins.
  always_comb begin
    busy_next = busy;
    if (pop) begin
      busy_next[head.rd] = 1'b0;
    end
    if (iss_fire) begin
      busy_next[bus.iss_rd] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end
`else
  // Without the scoreboard nothing is ever busy and issue is never blocked.
  logic unused_sb_inputs;
  assign unused_sb_inputs = &{1'b0, bus.iss_valid, bus.iss_rd, bus.rs1, bus.rs2};
  assign bus.iss_ready = 1'b1;
  assign bus.rs1_busy  = 1'b0;
  assign bus.rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter. Scoreboard
// expectations follow REGFILE_WRARB_SCOREBOARD_EN when the bench is compiled.
module tb_regfile_write_arbiter;

`ifdef REGFILE_WRARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'd0;
    bus.lu_valid  = 1'b0;
    bus.lu_rd     = 5'd0;
    bus.lu_data   = 32'd0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = 5'd0;
    bus.rs1       = 5'd0;
    bus.rs2       = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    // reset values
    check("rst_rf_we",     32'(bus.rf_we),     32'd0);
    check("rst_rf_rd",     32'(bus.rf_rd),     32'd0);
    check("rst_rf_data",   bus.rf_data,        32'd0);
    check("rst_lu_ready",  32'(bus.lu_ready),  32'd1);
    check("rst_wb_ready",  32'(bus.wb_ready),  32'd1);
    check("rst_iss_ready", 32'(bus.iss_ready), 32'd1);
    check("rst_rs1_busy",  32'(bus.rs1_busy),  32'd0);
    tick();
    rst = 1'b1;

    // traffic, then asynchronous reset mid-operation
    bus.wb_valid = 1'b1;  bus.wb_rd = 5'd2;  bus.wb_data = 32'h22;
    bus.lu_valid = 1'b1;  bus.lu_rd = 5'd4;  bus.lu_data = 32'h44;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    tick();
    check("pre_rst_rf_rd", 32'(bus.rf_rd), 32'd2);
    bus.lu_valid = 1'b0;
    bus.iss_valid = 1'b0;
    bus.rs1 = 5'd4;
    check("pre_rst_rs1_busy", 32'(bus.rs1_busy), SB ? 32'd1 : 32'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_rf_we",     32'(bus.rf_we),     32'd0);
    check("arst_rf_rd",     32'(bus.rf_rd),     32'd0);
    check("arst_rf_data",   bus.rf_data,        32'd0);
    check("arst_lu_ready",  32'(bus.lu_ready),  32'd1);
    check("arst_rs1_busy",  32'(bus.rs1_busy),  32'd0);
    check("arst_iss_ready", 32'(bus.iss_ready), 32'd1);
    idle_inputs();
    rst = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hA5;
    check("post_rst_wb_ready", 32'(bus.wb_ready), 32'd1);
    tick();
    check("post_rst_rf_we",   32'(bus.rf_we), 32'd1);
    check("post_rst_rf_rd",   32'(bus.rf_rd), 32'd5);
    check("post_rst_rf_data", bus.rf_data,    32'hA5);
    bus.wb_valid = 1'b0;
    tick();
    check("rst_dropped_fifo", 32'(bus.rf_we), 32'd0);

    // starvation: buffered rd=7 loses 4 times, then is forced
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h100;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'h11;
    check("starve_push_ready", 32'(bus.lu_ready), 32'd1);
    tick();
    bus.lu_valid = 1'b0;
    check("starve_wb_first", 32'(bus.rf_rd), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("starve_wb_ready_%0d", i), 32'(bus.wb_ready), 32'd1);
      tick();
      check($sformatf("starve_wb_win_%0d", i), 32'(bus.rf_rd), 32'd1);
    end
    check("starve_forced_wb_ready", 32'(bus.wb_ready), 32'd0);
    tick();
    check("starve_forced_we",   32'(bus.rf_we), 32'd1);
    check("starve_forced_rd",   32'(bus.rf_rd), 32'd7);
    check("starve_forced_data", bus.rf_data,    32'h11);
    check("starve_after_ready", 32'(bus.wb_ready), 32'd1);
    tick();
    check("starve_after_rd", 32'(bus.rf_rd), 32'd1);

    // fill the FIFO while writeback holds the port, then drain in order
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd10; bus.lu_data = 32'hA0;
    tick();
    bus.lu_rd = 5'd11; bus.lu_data = 32'hB0;
    check("fill_second_ready", 32'(bus.lu_ready), 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    bus.lu_rd = 5'd12; bus.lu_data = 32'hC0;
    check("fill_full_ready", 32'(bus.lu_ready), 32'd0);
    tick();
    check("drain_0_rd",   32'(bus.rf_rd), 32'd10);
    check("drain_0_data", bus.rf_data,    32'hA0);
    check("drain_reopen", 32'(bus.lu_ready), 32'd1);
    tick();
    bus.lu_valid = 1'b0;
    check("drain_1_rd", 32'(bus.rf_rd), 32'd11);
    tick();
    check("drain_2_rd",   32'(bus.rf_rd), 32'd12);
    check("drain_2_data", bus.rf_data,    32'hC0);
    tick();
    check("drain_empty_we", 32'(bus.rf_we), 32'd0);

    // scoreboard set on issue, clear on buffered grant
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    check("sb_issue_ready", 32'(bus.iss_ready), 32'd1);
    tick();
    bus.iss_valid = 1'b0;
    bus.rs1 = 5'd9; bus.rs2 = 5'd9;
    check("sb_rs1_busy", 32'(bus.rs1_busy),  SB ? 32'd1 : 32'd0);
    check("sb_rs2_busy", 32'(bus.rs2_busy),  SB ? 32'd1 : 32'd0);
    check("sb_waw",      32'(bus.iss_ready), SB ? 32'd0 : 32'd1);
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 32'h99;
    tick();
    bus.lu_valid = 1'b0;
    check("sb_busy_till_grant", 32'(bus.rs1_busy), SB ? 32'd1 : 32'd0);
    tick();
    check("sb_grant_rd",   32'(bus.rf_rd),    32'd9);
    check("sb_rs1_clear",  32'(bus.rs1_busy), 32'd0);
    check("sb_iss_reopen", 32'(bus.iss_ready), 32'd1);

    // same-cycle clear and set of rd=3: set wins
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd3; bus.lu_data = 32'h33;
    tick();
    bus.lu_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    check("setwin_iss_ready", 32'(bus.iss_ready), 32'd1);
    tick();
    bus.iss_valid = 1'b0;
    bus.rs1 = 5'd3;
    check("setwin_grant_rd", 32'(bus.rf_rd),     32'd3);
    check("setwin_rs1_busy", 32'(bus.rs1_busy),  SB ? 32'd1 : 32'd0);
    check("setwin_waw",      32'(bus.iss_ready), SB ? 32'd0 : 32'd1);

    // writes to x0 handshake but never assert rf_we
    bus.rs1 = 5'd0; bus.iss_rd = 5'd0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_data = 32'hBEEF;
    check("x0_wb_ready",  32'(bus.wb_ready),  32'd1);
    check("x0_iss_ready", 32'(bus.iss_ready), 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    bus.lu_valid = 1'b0;
    check("x0_wb_we", 32'(bus.rf_we), 32'd0);
    tick();
    check("x0_lu_we", 32'(bus.rf_we), 32'd0);
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd6; bus.lu_data = 32'h66;
    tick();
    bus.lu_valid = 1'b0;
    check("x0_popped_idle", 32'(bus.rf_we), 32'd0);
    tick();
    check("x0_popped_we",   32'(bus.rf_we), 32'd1);
    check("x0_popped_rd",   32'(bus.rf_rd), 32'd6);
    check("x0_popped_data", bus.rf_data,    32'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
